vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Frame-timing sequencer for the VGA controller. It divides the system clock into a pixel tick, steps the horizontal counter through the display, front-porch, sync and back-porch phases, and advances the vertical counter once per line. It generates HSync, VSync and VideoOn, plus line-end and frame-end strobes for the pixel generator. It replaces ad-hoc wiring between separate horizontal and vertical counters with one controller that owns both sequences.

## Interface
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, Clock cycles per pixel (≥1)

Ports:
- Clock  in  1  system clock; single clock domain.
- Clear  in  1  synchronous, active-high reset.
- Enable  in  1  run control; low freezes the counters.
- PixelTick  out  1  pixel-rate strobe, one Clock wide.
- HCount  out  10  horizontal position 0..H_TOTAL-1.
- VCount  out  10  vertical position 0..V_TOTAL-1.
- HState  out  2  horizontal phase: 0 DISP, 1 FP, 2 SYNC, 3 BACK.
- VState  out  2  vertical phase, same encoding.
- HSync  out  1  active-low horizontal sync.
- VSync  out  1  active-low vertical sync.
- VideoOn  out  1  high inside the visible area while enabled.
- LineEnd  out  1  strobe on the last pixel tick of a line.
- FrameEnd  out  1  strobe on the last pixel tick of a frame.

## Operation
- Derived constants:
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
  - Both totals must be ≤1024. Elaboration fails otherwise.
- Divider:
  - A register DivCnt runs 0..CLK_DIV-1 while Enable=1.
  - DivCnt is forced to 0 while Enable=0.
  - PixelTick = Enable && DivCnt==CLK_DIV-1.
  - With CLK_DIV=1, PixelTick = Enable.
- Horizontal counter:
  - On a Clock edge with PixelTick=1, HCount increments.
  - From H_TOTAL-1 it wraps to 0.
- Horizontal FSM (HState is registered and updated on the same tick as HCount):
  - DISP→FP when the next HCount is H_DISP.
  - FP→SYNC at H_DISP+H_FP.
  - SYNC→BACK at H_DISP+H_FP+H_SYNC.
  - BACK→DISP on wrap to 0.
  - HState must always equal the phase decoded from HCount.
- Vertical counter:
  - Advances only on a tick where LineEnd=1.
  - Wraps from V_TOTAL-1 to 0.
  - VState follows the same transition rules using the V_* parameters.
- Combinational outputs, decoded from registers:
  - HSync = !(HState==SYNC).
  - VSync = !(VState==SYNC).
  - VideoOn = Enable && HState==DISP && VState==DISP.
  - LineEnd = PixelTick && HCount==H_TOTAL-1.
  - FrameEnd = LineEnd && VCount==V_TOTAL-1.
- Enable=0: HCount, VCount, HState and VState hold their values. HSync and VSync keep reflecting the held states.
- Clear has priority over Enable and over ticks.

## Timing
- Reset values, one edge after Clear=1:
  - DivCnt=0, HCount=0, VCount=0.
  - HState=DISP, VState=DISP.
  - HSync=1, VSync=1, PixelTick=0, LineEnd=0, FrameEnd=0.
  - VideoOn equals Enable.
- Clear asserted mid-line or mid-frame: all registers take reset values on the next edge. No partial line is emitted.
- Enable rising: the first PixelTick comes CLK_DIV edges later. HCount first changes on that edge.
- Enable falling mid-pixel: the partial divider count is discarded. The position is kept.
- Period at CLK_DIV=2:
  - Line = 1600 Clock cycles.
  - Frame = 840000 Clock cycles.
- HSync is low for HCount 656..751, which is 96 pixels = 192 Clock cycles.
- VSync is low for VCount 490..491.
- Simultaneous H and V wrap: on the FrameEnd edge, HCount→0, VCount→0, HState→DISP and VState→DISP together.

## Test plan
- Reset, then Enable=1 at CLK_DIV=2:
  - PixelTick first appears on cycle 2, then every 2 cycles.
  - HCount reaches 1 after 2 cycles.
  - VideoOn=1 at (0,0).
- Line scan:
  - HState goes DISP→FP at HCount 640, FP→SYNC at 656, SYNC→BACK at 752.
  - HSync low exactly 192 cycles.
  - LineEnd pulses once at HCount 799, after which VCount=1.
- Full frame:
  - VSync is low only for lines 490–491.
  - FrameEnd pulses once per 840000 cycles, and both counters read 0 on the following cycle.
- Enable deasserted at HCount 300 for 50 cycles: HCount stays 300, VideoOn=0 and PixelTick=0. Counting resumes 2 cycles after re-enable.
- Clear pulsed at VCount 200, HCount 700 (SYNC): next cycle HCount=0, VCount=0, HSync=1, HState=DISP.
- Clear and Enable both high: Clear wins. The counters stay 0 until Clear drops.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: frame-timing sequencer for the VGA controller.
// Divides the system clock into a pixel tick and owns both the horizontal and
// vertical position counters and their DISP/FP/SYNC/BACK phase machines, so
// sync, blanking and line/frame strobes all come from one coherent source.
module vga_timing_ctrl #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 2
) (
  input  logic       Clock,
  input  logic       Clear,
  input  logic       Enable,
  output logic       PixelTick,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic [1:0] HState,
  output logic [1:0] VState,
  output logic       HSync,
  output logic       VSync,
  output logic       VideoOn,
  output logic       LineEnd,
  output logic       FrameEnd
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Counters are 10 bits wide, and every phase must last at least one step so
  // the one-step-at-a-time phase machines stay aligned with the counters.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_ctrl: CLK_DIV must be at least 1");
  end
  if (H_DISP < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_DISP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_phase
    $error("vga_timing_ctrl: every timing phase must be at least 1 long");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START   = 10'(H_DISP);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_DISP + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_DISP);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_DISP + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_DISP = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BACK = 2'd3
  } phase_e;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_count_q, h_count_d;
  logic [9:0]       v_count_q, v_count_d;
  phase_e           h_state_q, h_state_d;
  phase_e           v_state_q, v_state_d;

  logic pixel_tick;
  logic line_end;
  logic frame_end;

  // Phase transition rule shared by both axes: advance one phase when the
  // counter is about to land on the first position of the next phase.
  function automatic phase_e next_phase(input phase_e     cur,
                                        input logic [9:0] nxt,
                                        input logic [9:0] fp_start,
                                        input logic [9:0] sync_start,
                                        input logic [9:0] bp_start);
    phase_e res;
    res = cur;
    case (cur)
      PH_DISP: if (nxt == fp_start)   res = PH_FP;
      PH_FP:   if (nxt == sync_start) res = PH_SYNC;
      PH_SYNC: if (nxt == bp_start)   res = PH_BACK;
      PH_BACK: if (nxt == 10'd0)      res = PH_DISP;
      default: res = PH_DISP;
    endcase
    return res;
  endfunction

  assign pixel_tick = Enable && (div_cnt_q == DIV_LAST);
  assign line_end   = pixel_tick && (h_count_q == H_LAST);
  assign frame_end  = line_end && (v_count_q == V_LAST);

  // Pixel divider: counts enabled cycles, restarting on each tick; a low
  // Enable throws away any partial pixel.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!Enable) begin
      div_cnt_d = '0;
    end else if (pixel_tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Horizontal position and phase step together on every pixel tick.
  always_comb begin
    h_count_d = h_count_q;
    h_state_d = h_state_q;
    if (pixel_tick) begin
      h_count_d = line_end ? 10'd0 : h_count_q + 10'd1;
      h_state_d = next_phase(h_state_q, h_count_d,
                             H_FP_START, H_SYNC_START, H_BP_START);
    end
  end

  // Vertical position and phase step together once per line, on the last tick.
  always_comb begin
    v_count_d = v_count_q;
    v_state_d = v_state_q;
    if (line_end) begin
      v_count_d = frame_end ? 10'd0 : v_count_q + 10'd1;
      v_state_d = next_phase(v_state_q, v_count_d,
                             V_FP_START, V_SYNC_START, V_BP_START);
    end
  end

  // State registers; Clear overrides Enable and ticks.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      div_cnt_q <= '0;
      h_count_q <= 10'd0;
      v_count_q <= 10'd0;
      h_state_q <= PH_DISP;
      v_state_q <= PH_DISP;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
    end
  end

  assign PixelTick = pixel_tick;
  assign HCount    = h_count_q;
  assign VCount    = v_count_q;
  assign HState    = h_state_q;
  assign VState    = v_state_q;
  assign HSync     = !(h_state_q == PH_SYNC);
  assign VSync     = !(v_state_q == PH_SYNC);
  assign VideoOn   = Enable && (h_state_q == PH_DISP) && (v_state_q == PH_DISP);
  assign LineEnd   = line_end;
  assign FrameEnd  = frame_end;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for vga_timing_ctrl using a shrunken
// raster so whole frames, wraps and sync windows are exercised many times.
// The reference model tracks only "pixel index within the frame" and
// "enabled cycles since the last pixel", deriving everything else by
// division and range checks.
module tb_vga_timing_ctrl;

  localparam int HD  = 8;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 2;
  localparam int VD  = 4;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam int DIV = 3;
  localparam int HT  = HD + HF + HS + HB;
  localparam int VT  = VD + VF + VS + VB;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic [1:0] hst;
    logic [1:0] vst;
    logic       hsync;
    logic       vsync;
    logic       video;
    logic       lend;
    logic       fend;
  } obs_t;

  logic       clock;
  logic       clear;
  logic       enable;
  logic       pixelTick;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic [1:0] hState;
  logic [1:0] vState;
  logic       hSync;
  logic       vSync;
  logic       videoOn;
  logic       lineEnd;
  logic       frameEnd;

  int vectors     = 0;
  int miscompares = 0;

  obs_t expQ[$];

  int modelPos   = 0;
  int modelPhase = 0;
  bit modelValid = 0;
  bit prevClr    = 1;
  bit prevEn     = 0;

  vga_timing_ctrl #(
    .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV)
  ) dut (
    .Clock(clock),
    .Clear(clear),
    .Enable(enable),
    .PixelTick(pixelTick),
    .HCount(hCount),
    .VCount(vCount),
    .HState(hState),
    .VState(vState),
    .HSync(hSync),
    .VSync(vSync),
    .VideoOn(videoOn),
    .LineEnd(lineEnd),
    .FrameEnd(frameEnd)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Phase of a position given the lengths of the first three phases.
  function automatic logic [1:0] phaseOf(input int c, input int d, input int f, input int s);
    if (c < d) return 2'd0;
    if (c < d + f) return 2'd1;
    if (c < d + f + s) return 2'd2;
    return 2'd3;
  endfunction

  // Expected outputs for the current model position with this cycle's Enable.
  function automatic obs_t expectOutputs(input bit en);
    obs_t e;
    int h, v;
    h = modelPos % HT;
    v = modelPos / HT;
    e.tick  = en && (modelPhase == DIV - 1);
    e.h     = 10'(h);
    e.v     = 10'(v);
    e.hst   = phaseOf(h, HD, HF, HS);
    e.vst   = phaseOf(v, VD, VF, VS);
    e.hsync = (e.hst != 2'd2);
    e.vsync = (e.vst != 2'd2);
    e.video = en && (e.hst == 2'd0) && (e.vst == 2'd0);
    e.lend  = e.tick && (h == HT - 1);
    e.fend  = e.lend && (v == VT - 1);
    return e;
  endfunction

  // Advance the model by one clock edge taken with the given inputs.
  task automatic stepModel(input bit clr, input bit en);
    if (clr) begin
      modelPos   = 0;
      modelPhase = 0;
      modelValid = 1;
    end else if (!en) begin
      modelPhase = 0;
    end else if (modelPhase == DIV - 1) begin
      modelPhase = 0;
      modelPos   = (modelPos + 1) % (HT * VT);
    end else begin
      modelPhase = modelPhase + 1;
    end
  endtask

  // One cycle of stimulus: account for the edge just taken, drive new inputs
  // and queue the response the DUT should present before the next edge.
  task automatic applyStimulus(input bit clr, input bit en);
    @(posedge clock);
    #1;
    stepModel(prevClr, prevEn);
    clear  = clr;
    enable = en;
    if (modelValid) expQ.push_back(expectOutputs(en));
    prevClr = clr;
    prevEn  = en;
  endtask

  task automatic checkOutput(input obs_t e, input obs_t a);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("[TB] FAIL outputs @%0t: got tick=%b h=%0d v=%0d hst=%0d vst=%0d hs=%b vs=%b vid=%b le=%b fe=%b, exp tick=%b h=%0d v=%0d hst=%0d vst=%0d hs=%b vs=%b vid=%b le=%b fe=%b",
               $time, a.tick, a.h, a.v, a.hst, a.vst, a.hsync, a.vsync, a.video, a.lend, a.fend,
               e.tick, e.h, e.v, e.hst, e.vst, e.hsync, e.vsync, e.video, e.lend, e.fend);
    end
  endtask

  // Monitor: mid-cycle, compare whatever the DUT presents against the queue.
  always @(negedge clock) begin
    obs_t act;
    if (expQ.size() > 0) begin
      act.tick  = pixelTick;
      act.h     = hCount;
      act.v     = vCount;
      act.hst   = hState;
      act.vst   = vState;
      act.hsync = hSync;
      act.vsync = vSync;
      act.video = videoOn;
      act.lend  = lineEnd;
      act.fend  = frameEnd;
      checkOutput(expQ.pop_front(), act);
    end
  end

  // Run enabled until the model reaches the given position, within a budget.
  task automatic runTo(input int h, input int v, input string what);
    bit hit;
    hit = 0;
    for (int i = 0; i < 4 * HT * VT * DIV; i++) begin
      if ((modelPos % HT) == h && (modelPos / HT) == v) begin
        hit = 1;
        break;
      end
      applyStimulus(0, 1);
    end
    if (!hit) begin
      miscompares++;
      $display("[TB] FAIL %s: position not reached, got h=%0d v=%0d, required h=%0d v=%0d",
               what, modelPos % HT, modelPos / HT, h, v);
    end
  endtask

  initial begin
    clear  = 1'b1;
    enable = 1'b0;
    $display("[TB] start: raster %0dx%0d, divide by %0d", HT, VT, DIV);

    // Reset with Enable low, then Clear and Enable together.
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    applyStimulus(1, 1);

    // Two uninterrupted frames covering every phase, wrap and strobe.
    repeat (2 * HT * VT * DIV + 5) applyStimulus(0, 1);

    // Pause mid-line for 50 cycles, including a partial pixel, then resume.
    runTo(5, 1, "pause point");
    applyStimulus(0, 1);
    repeat (50) applyStimulus(0, 0);
    repeat (4 * DIV) applyStimulus(0, 1);

    // Clear mid-frame while in horizontal sync.
    runTo(HD + HF + 1, 2, "sync clear point");
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    repeat (3 * DIV) applyStimulus(0, 1);

    // Randomized Enable gaps and occasional Clear.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0);
    end

    // Drain the scoreboard.
    applyStimulus(0, 1);
    @(posedge clock);
    @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending entries, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
